johnson_phase_decoder: RTL

Downstream consumer of the Johnson counter's `out` bus. It validates every sampled code and converts legal codes to a one-hot phase strobe and a binary phase index. It also tracks whether the counter is advancing in correct sequence (lock FSM), flags illegal codes or sequence breaks with a sticky error, and counts completed Johnson cycles. It feeds phase-sequenced logic (multiphase enables, timing strobes) that must never act on a corrupted counter.

---
 rtl/johnson_pkg.sv | 60 ++++++
 rtl/johnson_code_check.sv | 26 ++
 rtl/johnson_phase_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg
// Shared types and helpers for decoding Johnson (twisted-ring) counter codes.
//   jc_state_e  : lock FSM state encoding
//   jc_code_of  : Johnson code for phase index k at width w
//   jc_is_legal : 1 when code is one of the 2*w legal Johnson codes
//   jc_to_idx   : phase index of a legal code (0 for illegal codes)
// Helpers take the counter width as an argument. Codes are passed
// zero-extended to JC_MAX_W bits.
package johnson_pkg;

  localparam int unsigned JC_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } jc_state_e;

  // Phases 0..w fill ones from the LSB; phases w+1..2w-1 drain them from the LSB.
  function automatic logic [JC_MAX_W-1:0] jc_code_of(input int unsigned k, input int unsigned w);
    logic [JC_MAX_W-1:0] one_v;
    logic [JC_MAX_W-1:0] mask_v;
    logic [JC_MAX_W-1:0] code_v;
    one_v  = {{(JC_MAX_W-1){1'b0}}, 1'b1};
    mask_v = (one_v << w) - one_v;
    if (k <= w) begin
      code_v = (one_v << k) - one_v;
    end else begin
      code_v = mask_v ^ ((one_v << (k - w)) - one_v);
    end
    return code_v;
  endfunction

  function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] code, input int unsigned w);
    logic legal_v;
    legal_v = 1'b0;
    for (int unsigned k = 0; k < 2 * JC_MAX_W; k++) begin
      if ((k < 2 * w) && (code == jc_code_of(k, w))) begin
        legal_v = 1'b1;
      end else begin
        legal_v = legal_v;
      end
    end
    return legal_v;
  endfunction

  function automatic int unsigned jc_to_idx(input logic [JC_MAX_W-1:0] code, input int unsigned w);
    int unsigned idx_v;
    idx_v = 0;
    for (int unsigned k = 0; k < 2 * JC_MAX_W; k++) begin
      if ((k < 2 * w) && (code == jc_code_of(k, w))) begin
        idx_v = k;
      end else begin
        idx_v = idx_v;
      end
    end
    return idx_v;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check
// Combinational classifier for one Johnson code sample.
//   jc_in : WIDTH-bit code from the counter
//   legal : code is one of the 2*WIDTH legal Johnson codes
//   idx   : phase index of the code (0 when illegal)
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] jc_in,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  logic [JC_MAX_W-1:0] code_s;

  // Zero-extend the sample and classify it.
  always_comb begin
    code_s = JC_MAX_W'(jc_in);
    legal  = jc_is_legal(code_s, unsigned'(WIDTH));
    idx    = IDX_W'(jc_to_idx(code_s, unsigned'(WIDTH)));
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
// Validates Johnson counter samples, decodes phase, tracks sequence lock.
//   clk, rst     : clock and synchronous active-high reset
//   in_valid     : jc_in is sampled this cycle
//   jc_in        : Johnson code from the counter
//   err_clr      : clears the sticky error (a same-cycle set wins)
//   phase_oh     : one-hot phase strobe
//   phase_idx    : binary phase index
//   phase_valid  : outputs reflect a legal code sampled last cycle
//   locked       : sequence lock achieved
//   wrap         : pulse on a locked 2W-1 -> 0 succession
//   err          : sticky error (illegal code or break while locked)
//   cyc_cnt      : count of wrap pulses, wrapping modulo 2^CYC_W
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int CYC_W    = 8,
  localparam int IDX_W    = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     jc_in,
  input  logic                 err_clr,
  output logic [2*WIDTH-1:0]   phase_oh,
  output logic [IDX_W-1:0]     phase_idx,
  output logic                 phase_valid,
  output logic                 locked,
  output logic                 wrap,
  output logic                 err,
  output logic [CYC_W-1:0]     cyc_cnt
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(2 * WIDTH - 1);
  localparam logic [RUN_W-1:0]   RUN_LOCK = RUN_W'(LOCK_CNT);
  localparam logic [2*WIDTH-1:0] OH_ONE   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  jc_state_e          state_r, state_n;
  logic [RUN_W-1:0]   run_r, run_n;
  logic [IDX_W-1:0]   idx_prev_r, idx_prev_n;
  logic [2*WIDTH-1:0] phase_oh_r, phase_oh_n;
  logic [IDX_W-1:0]   phase_idx_r, phase_idx_n;
  logic               phase_valid_r, phase_valid_n;
  logic               locked_r;
  logic               wrap_r, wrap_n;
  logic               err_r, err_n;
  logic [CYC_W-1:0]   cyc_r, cyc_n;

  logic               legal_s;
  logic [IDX_W-1:0]   idx_s;
  logic [IDX_W-1:0]   succ_idx_s;
  logic               succ_s;
  logic               err_set_s;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_check (
    .jc_in (jc_in),
    .legal (legal_s),
    .idx   (idx_s)
  );

  // Expected next index; 2W need not be a power of two, so wrap explicitly.
  always_comb begin
    if (idx_prev_r == LAST_IDX) begin
      succ_idx_s = '0;
    end else begin
      succ_idx_s = idx_prev_r + IDX_W'(1);
    end
    succ_s = legal_s && (idx_s == succ_idx_s);
  end

  // Lock FSM next-state, next output values and error/cycle bookkeeping.
  always_comb begin
    state_n       = state_r;
    run_n         = run_r;
    idx_prev_n    = idx_prev_r;
    phase_oh_n    = phase_oh_r;
    phase_idx_n   = phase_idx_r;
    phase_valid_n = 1'b0;
    wrap_n        = 1'b0;
    err_set_s     = 1'b0;
    cyc_n         = cyc_r;
    err_n         = err_r;

    if (in_valid) begin
      if (legal_s) begin
        idx_prev_n    = idx_s;
        phase_idx_n   = idx_s;
        phase_oh_n    = OH_ONE << idx_s;
        phase_valid_n = 1'b1;
      end else begin
        phase_oh_n    = '0;
        err_set_s     = 1'b1;
      end

      case (state_r)
        ST_UNLOCKED: begin
          if (legal_s) begin
            state_n = ST_ACQUIRE;
            run_n   = '0;
          end else begin
            state_n = ST_UNLOCKED;
          end
        end
        ST_ACQUIRE: begin
          if (!legal_s) begin
            state_n = ST_UNLOCKED;
            run_n   = '0;
          end else if (succ_s) begin
            run_n = run_r + RUN_W'(1);
            if ((run_r + RUN_W'(1)) == RUN_LOCK) begin
              state_n = ST_LOCKED;
            end else begin
              state_n = ST_ACQUIRE;
            end
          end else begin
            run_n = '0;
          end
        end
        ST_LOCKED: begin
          if (succ_s) begin
            // succ_s with prev == LAST_IDX implies the new index is 0.
            wrap_n = (idx_prev_r == LAST_IDX);
          end else begin
            state_n   = ST_UNLOCKED;
            run_n     = '0;
            err_set_s = 1'b1;
          end
        end
        default: begin
          state_n = ST_UNLOCKED;
          run_n   = '0;
        end
      endcase
    end else begin
      phase_valid_n = 1'b0;
    end

    if (wrap_n) begin
      cyc_n = cyc_r + CYC_W'(1);
    end else begin
      cyc_n = cyc_r;
    end

    if (err_set_s) begin
      err_n = 1'b1;
    end else if (err_clr) begin
      err_n = 1'b0;
    end else begin
      err_n = err_r;
    end
  end

  // FSM state, run counter and last accepted index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_UNLOCKED;
      run_r      <= '0;
      idx_prev_r <= '0;
    end else begin
      state_r    <= state_n;
      run_r      <= run_n;
      idx_prev_r <= idx_prev_n;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_oh_r    <= '0;
      phase_idx_r   <= '0;
      phase_valid_r <= 1'b0;
      locked_r      <= 1'b0;
      wrap_r        <= 1'b0;
      err_r         <= 1'b0;
      cyc_r         <= '0;
    end else begin
      phase_oh_r    <= phase_oh_n;
      phase_idx_r   <= phase_idx_n;
      phase_valid_r <= phase_valid_n;
      locked_r      <= (state_n == ST_LOCKED);
      wrap_r        <= wrap_n;
      err_r         <= err_n;
      cyc_r         <= cyc_n;
    end
  end

  assign phase_oh    = phase_oh_r;
  assign phase_idx   = phase_idx_r;
  assign phase_valid = phase_valid_r;
  assign locked      = locked_r;
  assign wrap        = wrap_r;
  assign err         = err_r;
  assign cyc_cnt     = cyc_r;

endmodule
